// File: rtl/shift_add_multiplier_pkg.sv
// Shared arithmetic package for the iterative multiply/divide blocks.
// Holds state encodings and small sizing helpers.
package shift_add_multiplier_pkg;

   typedef enum logic {
      MUL_IDLE,
      MUL_LOOP
   } mul_state_t;

   function automatic int cnt_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-and-add multiplier, one partial product per clock.
// Signed mode multiplies magnitudes and negates the result at the end.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int N_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_BITS-1:0]     multiplicand,
   input  logic [N_BITS-1:0]     multiplier,
   input  logic                  operands_signed,
   input  logic                  start,
   output logic                  busy,
   output logic [2*N_BITS-1:0]   product,
   output logic                  result_valid
);

   localparam int CW = cnt_width(N_BITS);
   localparam int PW = 2 * N_BITS;

   mul_state_t        state;
   mul_state_t        state_nxt;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     mcand;
   logic [PW-1:0]     acc_sum;
   logic [N_BITS-1:0] mplier;
   logic [N_BITS-1:0] mag_a;
   logic [N_BITS-1:0] mag_b;
   logic [CW-1:0]     cnt;
   logic              neg;
   logic              sign_a;
   logic              sign_b;
   logic              accept;
   logic              last;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      unique case (state)
         MUL_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = MUL_LOOP;
            end
         end
         MUL_LOOP: begin
            if (cnt == '0) begin
               last      = 1'b1;
               state_nxt = MUL_IDLE;
            end
         end
         default: state_nxt = MUL_IDLE;
      endcase
   end

   // -2^(N-1) negates to 2^(N-1), which still fits as an unsigned magnitude
   always_comb begin
      sign_a  = operands_signed & multiplicand[N_BITS-1];
      sign_b  = operands_signed & multiplier[N_BITS-1];
      mag_a   = sign_a ? -multiplicand : multiplicand;
      mag_b   = sign_b ? -multiplier : multiplier;
      acc_sum = acc + (mplier[0] ? mcand : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= MUL_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         cnt          <= '0;
         neg          <= 1'b0;
         product      <= '0;
         result_valid <= 1'b0;
      end else if (accept) begin
         acc          <= '0;
         mcand        <= {{N_BITS{1'b0}}, mag_a};
         mplier       <= mag_b;
         cnt          <= CW'(N_BITS - 1);
         neg          <= sign_a ^ sign_b;
         result_valid <= 1'b0;
      end else if (state == MUL_LOOP) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (last) begin
            product      <= neg ? -acc_sum : acc_sum;
            result_valid <= 1'b1;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign busy = (state == MUL_LOOP);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier, N_BITS=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_shift_add_multiplier;

   localparam int N = 8;

   logic          clk;
   logic          rst;
   logic [N-1:0]  multiplicand;
   logic [N-1:0]  multiplier;
   logic          operands_signed;
   logic          start;
   logic          busy;
   logic [2*N-1:0] product;
   logic          result_valid;

   int vectors;
   int miscompares;

   shift_add_multiplier #(.N_BITS(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .multiplicand    (multiplicand),
      .multiplier      (multiplier),
      .operands_signed (operands_signed),
      .start           (start),
      .busy            (busy),
      .product         (product),
      .result_valid    (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Caller is at a falling edge; returns at the falling edge after the result.
   task automatic do_mul(input string tag,
                         input logic [N-1:0] a,
                         input logic [N-1:0] b,
                         input logic s,
                         input logic [2*N-1:0] exp);
      multiplicand    = a;
      multiplier      = b;
      operands_signed = s;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy@start"}, 32'(busy), 32'd1);
      check({tag, " rv@start"}, 32'(result_valid), 32'd0);
      repeat (N - 1) @(negedge clk);
      check({tag, " busy@k+7"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({tag, " busy@k+8"}, 32'(busy), 32'd0);
      check({tag, " rv@k+8"}, 32'(result_valid), 32'd1);
      check({tag, " product"}, 32'(product), 32'(exp));
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst             = 1'b1;
      start           = 1'b0;
      multiplicand    = '0;
      multiplier      = '0;
      operands_signed = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset rv", 32'(result_valid), 32'd0);
      check("reset product", 32'(product), 32'd0);

      @(negedge clk);
      do_mul("u13x11", 8'd13, 8'd11, 1'b0, 16'd143);
      @(negedge clk);
      check("rv held idle", 32'(result_valid), 32'd1);
      check("product held idle", 32'(product), 32'd143);

      do_mul("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
      do_mul("s-7x6", 8'hF9, 8'd6, 1'b1, 16'hFFD6);
      do_mul("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000);
      do_mul("s-128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
      do_mul("uF9x6", 8'hF9, 8'd6, 1'b0, 16'h05D6);
      do_mul("s-1x-1", 8'hFF, 8'hFF, 1'b1, 16'h0001);
      do_mul("u0x200", 8'd0, 8'd200, 1'b0, 16'h0000);

      // Second start mid-LOOP must be ignored.
      multiplicand    = 8'd100;
      multiplier      = 8'd200;
      operands_signed = 1'b0;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      multiplicand    = 8'd7;
      multiplier      = 8'd9;
      operands_signed = 1'b1;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("ign busy@k+7", 32'(busy), 32'd1);
      @(negedge clk);
      check("ign rv", 32'(result_valid), 32'd1);
      check("ign product", 32'(product), 32'd20000);
      @(negedge clk);
      check("ign no restart", 32'(busy), 32'd0);

      // Back-to-back: start right after the result, product held meanwhile.
      do_mul("b2b first", 8'd12, 8'd12, 1'b0, 16'd144);
      multiplicand    = 8'd20;
      multiplier      = 8'd30;
      operands_signed = 1'b0;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b rv drop", 32'(result_valid), 32'd0);
      check("b2b product held", 32'(product), 32'd144);
      repeat (N - 1) @(negedge clk);
      check("b2b busy@k+7", 32'(busy), 32'd1);
      @(negedge clk);
      check("b2b rv", 32'(result_valid), 32'd1);
      check("b2b product", 32'(product), 32'd600);

      // Reset on the fourth LOOP cycle aborts with no result.
      multiplicand    = 8'd50;
      multiplier      = 8'd60;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort rv", 32'(result_valid), 32'd0);
      check("abort product", 32'(product), 32'd0);
      repeat (N) @(negedge clk);
      check("abort stays idle", 32'(result_valid), 32'd0);
      do_mul("post rst 3x5", 8'd3, 8'd5, 1'b0, 16'd15);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
